// File: rtl/loader_pkg.sv
// Shared definitions for the imem boot loader: FSM state encoding, framing
// constants and default sizing. Imported by the top and its word assembler.
package loader_pkg;

  // Loader FSM states, in the order a good frame walks through them.
  typedef enum logic [2:0] {
    SYNC,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERR
  } state_t;

  // Every frame opens with this byte; anything else in SYNC is line noise.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Largest image accepted by default, in 32-bit words.
  localparam int DEFAULT_MAX_WORDS = 4096;

  // The frame checksum is a single XOR byte over the payload.
  localparam int CSUM_W = 8;

  // Length field on the wire is two bytes, little-endian.
  localparam int LEN_W = 16;

endpackage

// File: rtl/loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words. The first byte of a
// word lands in bits [7:0]. word_valid is combinational and pulses together
// with the acceptance of the 4th byte, with word carrying the complete value
// on that same cycle, so the parent can register the write on that edge.
module loader_word_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  // Only the first three bytes of a word need storing; the 4th arrives live.
  logic [23:0] shreg;
  logic [1:0]  byte_cnt;

  // Shift accepted bytes in from the top so the oldest ends up in [7:0].
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (clr) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (byte_valid) begin
      shreg    <= {byte_data, shreg[23:8]};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  assign word_valid = byte_valid && (byte_cnt == 2'd3);
  assign word       = {byte_data, shreg};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a framed program image from a byte stream, writes it
// word by word into imem and keeps the processor in reset until the whole
// image has arrived with a matching XOR checksum.
//
// Frame: 0xA5, LEN_LO, LEN_HI, LEN*4 payload bytes, XOR-of-payload byte.
//
// Optional build macro LOADER_TIMEOUT_EN adds an idle timer: inside a frame,
// IDLE_TIMEOUT cycles without a byte transfer sends the loader to ERR.
// Without it the loader waits for bytes indefinitely.
//
// Handshake: a byte moves on a rising clock edge where rx_valid and rx_ready
// are both high. rx_ready is a registered output; it is dropped for exactly
// the cycle in which wr_en is high so that no byte is accepted while a word
// is being written, and it is low in DONE and ERR.
module imem_boot_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int MAX_WORDS    = DEFAULT_MAX_WORDS,
  parameter int IDLE_TIMEOUT = 65535
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              start,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              proc_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count,
  output state_t            dbg_state
);

  state_t            state;
  logic [7:0]        len_lo;
  logic [LEN_W-1:0]  len_q;
  logic [CSUM_W-1:0] checksum;

  logic              xfer;
  logic [LEN_W-1:0]  len_in;
  logic              len_too_big;
  logic              last_word;
  logic              asm_clr;
  logic              asm_byte;
  logic              word_valid;
  logic [31:0]       word;

  // A start pulse wins over a coincident byte, so it also masks the transfer.
  assign xfer        = rx_valid && rx_ready && !start;
  assign len_in      = {rx_data, len_lo};
  assign len_too_big = {1'b0, len_in} > (LEN_W+1)'(MAX_WORDS);
  assign last_word   = (LEN_W'(word_count) + LEN_W'(1)) == len_q;
  assign asm_clr     = start || (state != DATA);
  assign asm_byte    = xfer && (state == DATA);
  assign dbg_state   = state;

  loader_word_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .clr        (asm_clr),
    .byte_valid (asm_byte),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

`ifdef LOADER_TIMEOUT_EN
  localparam int TIMER_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  logic [TIMER_W-1:0] timer;
  logic               in_frame;

  assign in_frame = (state == LEN_LO) || (state == LEN_HI) ||
                    (state == DATA)   || (state == CHECK);
`endif

  // Loader FSM with registered outputs; the idle timer lives here as well so
  // that a timeout can override whatever the state case decided.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= SYNC;
      rx_ready   <= 1'b1;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      proc_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      checksum   <= '0;
      len_lo     <= '0;
      len_q      <= '0;
`ifdef LOADER_TIMEOUT_EN
      timer      <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      if (start) begin
        state      <= SYNC;
        rx_ready   <= 1'b1;
        proc_reset <= 1'b1;
        done       <= 1'b0;
        error      <= 1'b0;
        word_count <= '0;
        checksum   <= '0;
`ifdef LOADER_TIMEOUT_EN
        timer      <= '0;
`endif
      end else begin
        case (state)
          SYNC: begin
            if (xfer && (rx_data == SYNC_BYTE)) state <= LEN_LO;
          end
          LEN_LO: begin
            if (xfer) begin
              len_lo <= rx_data;
              state  <= LEN_HI;
            end
          end
          LEN_HI: begin
            if (xfer) begin
              len_q <= len_in;
              if (len_too_big) begin
                state      <= ERR;
                error      <= 1'b1;
                proc_reset <= 1'b1;
                rx_ready   <= 1'b0;
              end else if (len_in == '0) begin
                state <= CHECK;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (xfer) checksum <= checksum ^ rx_data;
            if (word_valid) begin
              wr_en    <= 1'b1;
              wr_data  <= word;
              wr_addr  <= word_count[ADDR_W-1:0];
              rx_ready <= 1'b0;
            end
            // The write cycle itself: count the word and reopen the byte port.
            if (wr_en) begin
              word_count <= word_count + (ADDR_W+1)'(1);
              rx_ready   <= 1'b1;
              if (last_word) state <= CHECK;
            end
          end
          CHECK: begin
            if (xfer) begin
              rx_ready <= 1'b0;
              if (rx_data == checksum) begin
                state      <= DONE;
                done       <= 1'b1;
                proc_reset <= 1'b0;
              end else begin
                state      <= ERR;
                error      <= 1'b1;
                proc_reset <= 1'b1;
              end
            end
          end
          DONE: begin
            rx_ready <= 1'b0;
          end
          ERR: begin
            rx_ready   <= 1'b0;
            proc_reset <= 1'b1;
          end
          default: begin
            state <= ERR;
            error <= 1'b1;
          end
        endcase
`ifdef LOADER_TIMEOUT_EN
        if (!in_frame || xfer) begin
          timer <= '0;
        end else if (timer == TIMER_W'(IDLE_TIMEOUT - 1)) begin
          timer      <= '0;
          state      <= ERR;
          error      <= 1'b1;
          proc_reset <= 1'b1;
          rx_ready   <= 1'b0;
          wr_en      <= 1'b0;
        end else begin
          timer <= timer + TIMER_W'(1);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader. Frames are built here from their contents; the
// expected writes and the final verdict come straight from the frame (words
// are payload bytes taken four at a time, success iff length fits and the
// checksum byte equals the XOR of the payload).
module tb_imem_boot_loader;
  import loader_pkg::*;

  localparam int ADDR_W       = 12;
  localparam int MAX_WORDS    = 4096;
  localparam int IDLE_TIMEOUT = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic              start = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              proc_reset;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;
  state_t            dbg_state;

  imem_boot_loader #(
    .ADDR_W       (ADDR_W),
    .MAX_WORDS    (MAX_WORDS),
    .IDLE_TIMEOUT (IDLE_TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .start      (start),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .proc_reset (proc_reset),
    .done       (done),
    .error      (error),
    .word_count (word_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;
  int max_gap = 2;
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] seen_q[$];
  logic [ADDR_W+31:0] exp_e;
  logic [7:0]         pay_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Every write strobe must match the next expected {addr, data}.
  always @(negedge clock) begin
    if (wr_en) begin
      check("wr_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(exp_e[ADDR_W+31:32]));
        check("wr_data", 64'(wr_data), 64'(exp_e[31:0]));
      end
      seen_q.push_back({wr_addr, wr_data});
      check("rdy_in_wr", 64'(rx_ready), 64'd0);
    end
  end

  // ---------------- drivers (called at a falling edge, return at one) ----------------
  task automatic send_byte(input logic [7:0] b);
    int budget;
    budget = 200;
    rx_valid = 1'b1;
    rx_data  = b;
    // rx_ready seen at a falling edge is what the next rising edge will use.
    while (!rx_ready && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (budget == 0) check("rx_ready_wait", 64'd0, 64'd1);
    @(negedge clock);
    rx_valid = 1'b0;
    repeat ($urandom_range(0, max_gap)) @(negedge clock);
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_state"}, 64'(dbg_state), 64'(SYNC));
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_preset"}, 64'(proc_reset), 64'd1);
    check({tag, "_wc"}, 64'(word_count), 64'd0);
    check({tag, "_rdy"}, 64'(rx_ready), 64'd1);
    check({tag, "_wren"}, 64'(wr_en), 64'd0);
  endtask

  task automatic pulse_start(input bit with_byte);
    start = 1'b1;
    if (with_byte) begin
      rx_valid = 1'b1;
      rx_data  = SYNC_BYTE;
    end
    @(negedge clock);
    start    = 1'b0;
    rx_valid = 1'b0;
    check_idle_state(with_byte ? "start_drop" : "start");
  endtask

  task automatic fill_pay(input int n);
    pay_q.delete();
    repeat (4 * n) pay_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic finish_frame(input string tag, input bit ok, input int wc);
    int budget;
    budget = 100;
    while (!(done || error) && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    check({tag, "_done"}, 64'(done), 64'(ok));
    check({tag, "_error"}, 64'(error), 64'(!ok));
    check({tag, "_preset"}, 64'(proc_reset), 64'(!ok));
    check({tag, "_rdy"}, 64'(rx_ready), 64'd0);
    check({tag, "_wc"}, 64'(word_count), 64'(wc));
    check({tag, "_state"}, 64'(dbg_state), ok ? 64'(DONE) : 64'(ERR));
    check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  // cs_mode: 0 correct checksum, 1 corrupted checksum, 2 literal cs_lit.
  task automatic send_frame(input string tag, input int garbage, input int len,
                            input int cs_mode, input logic [7:0] cs_lit);
    logic [15:0] l16;
    logic [7:0]  cs;
    logic [7:0]  b;
    bit          fits;
    l16  = 16'(len);
    cs   = 8'h00;
    fits = (len <= MAX_WORDS);
    if (fits)
      for (int i = 0; i < len; i++)
        exp_q.push_back({ADDR_W'(i), pay_q[4*i+3], pay_q[4*i+2], pay_q[4*i+1], pay_q[4*i]});
    for (int g = 0; g < garbage; g++) begin
      b = 8'($urandom_range(0, 255));
      if (b == SYNC_BYTE) b = 8'h00;
      send_byte(b);
    end
    send_byte(SYNC_BYTE);
    send_byte(l16[7:0]);
    send_byte(l16[15:8]);
    if (fits) begin
      foreach (pay_q[i]) begin
        send_byte(pay_q[i]);
        cs = cs ^ pay_q[i];
      end
      if (cs_mode == 0)      b = cs;
      else if (cs_mode == 1) b = cs ^ 8'($urandom_range(1, 255));
      else                   b = cs_lit;
      send_byte(b);
      finish_frame(tag, b == cs, len);
    end else begin
      finish_frame(tag, 1'b0, 0);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cyc;
    repeat (3) @(negedge clock);
    check_idle_state("reset");
    check("reset_wraddr", 64'(wr_addr), 64'd0);
    check("reset_wrdata", 64'(wr_data), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    // Clean two-word load with hand-computed writes.
    pay_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    seen_q.delete();
    send_frame("clean", 0, 2, 2, 8'h88);
    check("clean_w0", seen_q.size() > 0 ? 64'(seen_q[0]) : 64'hdead, 64'({12'h000, 32'h44332211}));
    check("clean_w1", seen_q.size() > 1 ? 64'(seen_q[1]) : 64'hdead, 64'({12'h001, 32'h88776655}));

    // Garbage ahead of the sync byte is discarded.
    pulse_start(1'b0);
    send_byte(8'h00);
    send_byte(8'hFF);
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    seen_q.delete();
    send_frame("garbage", 0, 1, 0, 8'h00);
    check("garbage_nwr", 64'(seen_q.size()), 64'd1);
    check("garbage_w0", seen_q.size() > 0 ? 64'(seen_q[0]) : 64'hdead, 64'({12'h000, 32'h04030201}));

    // Start coinciding with a sync byte drops the byte; then a bad checksum.
    pulse_start(1'b1);
    pay_q = '{8'h5A, 8'h00, 8'h00, 8'h00};
    send_frame("badcs", 0, 1, 2, 8'h00);

    // Oversize length: error right after LEN_HI, no writes.
    pulse_start(1'b0);
    pay_q.delete();
    send_frame("oversize", 0, 16'h1001, 0, 8'h00);

    // Zero-length image: checksum must be 0x00.
    pulse_start(1'b0);
    send_frame("len0", 0, 0, 0, 8'h00);

    // Start aborts a load halfway through the second word.
    pulse_start(1'b0);
    fill_pay(3);
    exp_q.push_back({ADDR_W'(0), pay_q[3], pay_q[2], pay_q[1], pay_q[0]});
    send_byte(SYNC_BYTE);
    send_byte(8'h03);
    send_byte(8'h00);
    for (int i = 0; i < 5; i++) send_byte(pay_q[i]);
    check("abort_w0_written", 64'(exp_q.size()), 64'd0);
    pulse_start(1'b0);
    fill_pay(2);
    send_frame("after_abort", 1, 2, 0, 8'h00);

    // Asynchronous reset in the middle of DATA.
    pulse_start(1'b0);
    fill_pay(2);
    exp_q.push_back({ADDR_W'(0), pay_q[3], pay_q[2], pay_q[1], pay_q[0]});
    send_byte(SYNC_BYTE);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 6; i++) send_byte(pay_q[i]);
    check("rst_w0_written", 64'(exp_q.size()), 64'd0);
    reset = 1'b0;
    #1;
    check_idle_state("midrst");
    check("midrst_wraddr", 64'(wr_addr), 64'd0);
    check("midrst_wrdata", 64'(wr_data), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    fill_pay(2);
    send_frame("after_rst", 0, 2, 0, 8'h00);

    // Randomized frames: random garbage, length, payload and checksum faults.
    for (int it = 0; it < 12; it++) begin
      pulse_start(1'b0);
      fill_pay($urandom_range(1, 6));
      send_frame("rand", $urandom_range(0, 3), pay_q.size() / 4,
                 ($urandom_range(0, 3) == 0) ? 1 : 0, 8'h00);
    end

`ifdef LOADER_TIMEOUT_EN
    // Stall after LEN_LO: error after exactly IDLE_TIMEOUT idle cycles.
    max_gap = 0;
    pulse_start(1'b0);
    send_byte(SYNC_BYTE);
    send_byte(8'h01);
    cyc = 0;
    while (!error && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    check("timeout_error", 64'(error), 64'd1);
    check("timeout_cycles", 64'(cyc), 64'(IDLE_TIMEOUT));
    check("timeout_preset", 64'(proc_reset), 64'd1);
    check("timeout_state", 64'(dbg_state), 64'(ERR));
    pulse_start(1'b0);
    max_gap = 2;
    fill_pay(2);
    send_frame("after_timeout", 0, 2, 0, 8'h00);
`else
    // Without the timer a long stall inside a frame is harmless.
    pulse_start(1'b0);
    send_byte(SYNC_BYTE);
    send_byte(8'h01);
    cyc = 0;
    repeat (IDLE_TIMEOUT * 3) begin
      @(negedge clock);
      cyc++;
    end
    check("notimer_error", 64'(error), 64'd0);
    check("notimer_state", 64'(dbg_state), 64'(LEN_HI));
    pay_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    exp_q.push_back({ADDR_W'(0), 32'hEFBEADDE});
    send_byte(8'h00);
    foreach (pay_q[i]) send_byte(pay_q[i]);
    send_byte(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
    finish_frame("notimer", 1'b1, 1);
`endif

    // Largest legal image: exactly MAX_WORDS words, back-to-back bytes.
    max_gap = 0;
    pulse_start(1'b0);
    fill_pay(MAX_WORDS);
    send_frame("maxlen", 0, MAX_WORDS, 0, 8'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Hard stop if the sequence ever wedges.
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sits upstream of the processor top level.
- Receives a program image as a byte stream, packs the bytes into 32-bit words and writes them sequentially into imem through a dedicated write port.
- Holds the processor in reset until the image is fully loaded and its checksum has been verified.
- Releases the processor only after a good load; on any failure the processor stays in reset.

Parameters:
- ADDR_W, 12, imem word-address width.
- MAX_WORDS, 4096, largest accepted image length in words.
- IDLE_TIMEOUT, 65535, maximum gap in cycles between bytes inside a frame.

Ports:
- clock  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_valid  in  1  byte available on rx_data.
- rx_data  in  8  incoming byte.
- rx_ready  out  1  loader can accept a byte; a transfer occurs when rx_valid and rx_ready are both high on a clock edge.
- start  in  1  one-cycle pulse: abort any load in progress and re-arm.
- wr_en  out  1  imem write strobe, one cycle per word.
- wr_addr  out  ADDR_W  imem word address.
- wr_data  out  32  assembled word.
- proc_reset  out  1  active-high reset hold driven to the processor.
- done  out  1  load completed and checksum matched.
- error  out  1  load failed.
- word_count  out  ADDR_W+1  number of words written so far.

Behaviour:
- Reset values: state=SYNC, rx_ready=1, wr_en=0, wr_addr=0, wr_data=0, proc_reset=1, done=0, error=0, word_count=0, checksum=0, timer=0.
- Frame format, in order:
  - sync byte 0xA5;
  - LEN_LO, then LEN_HI (N in words, little-endian);
  - N×4 payload bytes, each word little-endian (first byte is bits [7:0]);
  - one checksum byte equal to the XOR of all payload bytes.
- State SYNC: bytes other than 0xA5 are accepted and discarded; 0xA5 moves to LEN_LO.
- State LEN_LO: latch the low length byte, go to LEN_HI.
- State LEN_HI: form N.
  - N > MAX_WORDS: go to ERR.
  - N = 0: go to CHECK; the expected checksum is 0x00.
  - Otherwise: go to DATA.
- State DATA:
  - Shift bytes into the word; XOR each byte into checksum.
  - On acceptance of the 4th byte of a word: the next cycle drives wr_en=1, wr_data=word, wr_addr=word_count, then increments word_count.
  - After word N-1 is written, go to CHECK.
- State CHECK: compare the received byte with checksum.
  - Equal: go to DONE.
  - Not equal: go to ERR.
- State DONE: done=1, proc_reset=0, rx_ready=0.
- State ERR: error=1, proc_reset=1, rx_ready=0.
- rx_ready is 1 in SYNC, LEN_LO, LEN_HI, DATA and CHECK, with one exception: it is 0 during the wr_en cycle. This guarantees at most one byte is in flight per write.
- Timeout: in LEN_LO, LEN_HI, DATA or CHECK, the timer counts cycles without a transfer and clears on every transfer. Reaching IDLE_TIMEOUT goes to ERR.
- start pulse (any state): next state is SYNC; word_count, checksum and timer clear; done and error clear; proc_reset=1. If start coincides with a byte transfer, start wins and the byte is dropped.
- Asynchronous reset mid-load: everything returns to reset values immediately; a partially written imem is not erased.
- Address wrap cannot occur, because N ≤ MAX_WORDS ≤ 2^ADDR_W.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined: the idle timer and the timeout-to-ERR transition exist as described above.
- Undefined: no timer is built; the loader waits indefinitely for bytes, and ERR is reachable only through a length or checksum failure.

Decomposition:
- Shared package loader_pkg holds:
  - state enum (SYNC, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR);
  - SYNC_BYTE = 8'hA5;
  - default MAX_WORDS;
  - checksum width constant.
- One natural sub-module, loader_word_assembler: byte shifter plus 2-bit byte counter, producing word_valid and word.
- The FSM, timer and checksum logic stay in the top module.

Test Plan:
- Clean load: stream 0xA5, 0x02, 0x00, 11 22 33 44, 55 66 77 88, checksum 0x88 → wr_en pulses at addr 0 with data 0x44332211 and addr 1 with data 0x88776655; word_count=2; done=1; proc_reset falls to 0.
- Garbage before sync: bytes 0x00, 0xFF, then a valid N=1 frame → garbage is ignored; a single write at addr 0; done=1.
- Bad checksum: N=1 frame with checksum 0x00 when 0x5A is expected → error=1; proc_reset stays 1; rx_ready=0.
- Oversize length: LEN=0x1001 → ERR straight after LEN_HI, with no wr_en asserted.
- Timeout (LOADER_TIMEOUT_EN, IDLE_TIMEOUT=16): stall 16 cycles after LEN_LO → error=1. Then pulse start → state SYNC, error=0, and a subsequent clean load succeeds.
- Reset mid-DATA: drop reset after 6 payload bytes → all outputs return to reset values at once; a full frame sent afterwards loads from addr 0.
